// File: rtl/tiny_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM bus arbiter.
// Holds the access FSM state encoding, the ACCESS/DONE phase lengths and
// the 2-way round-robin pick helper used by tiny_rr_pick.
package tiny_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } arb_state_e;

    // Number of cycles the strobe phase and the settle phase each last.
    localparam int unsigned ACCESS_CYCLES = 1;
    localparam int unsigned DONE_CYCLES   = 1;

    // Phase counter width and the terminal counts it compares against.
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] ACCESS_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] DONE_LAST   = CNT_W'(DONE_CYCLES - 1);

    // Returns the requester id to grant; only meaningful when a request exists.
    // With both requesting, the one not granted last wins.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last_id);
        logic id;
        if (req0 && req1) begin
            id = ~last_id;
        end else if (req1) begin
            id = 1'b1;
        end else begin
            id = 1'b0;
        end
        return id;
    endfunction

endpackage

// File: rtl/tiny_rr_pick.sv
// Two-way round-robin pick: combinational grant selection plus the
// register remembering who was granted last. The bit only moves on a grant.
module tiny_rr_pick
    import tiny_bus_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_grant_en,
    output logic o_valid,
    output logic o_id
);

    logic r_last_id;
    logic w_id;

    assign w_id    = rr_pick(i_req0, i_req1, r_last_id);
    assign o_valid = i_req0 | i_req1;
    assign o_id    = w_id;

    // Remember the last grantee; reset value 1 makes m0 win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_id <= 1'b1;
        end else if (i_grant_en && o_valid) begin
            r_last_id <= w_id;
        end
    end

endmodule

// File: rtl/tiny_bus_arbiter.sv
// Two-requester arbiter in front of a shared code/data RAM bus.
// Each access runs IDLE -> ACCESS (one strobe cycle) -> DONE -> IDLE, with the
// grantee's ack and read data registered on the DONE->IDLE edge.
// Optional feature: define TINY_ARB_LOCK_EN to add m0_lock/m1_lock inputs that
// let a grantee keep the bus for back-to-back accesses while it keeps requesting.
module tiny_bus_arbiter
    import tiny_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic              m0_ramsel,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic              m1_ramsel,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
`ifdef TINY_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              ramsel,
    input  logic [DATA_W-1:0] rdata
);

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_start;
    logic             w_done;

    logic             w_req0;
    logic             w_req1;
    logic             w_gnt_valid;
    logic             w_gnt_id;

    logic              r_gnt_id;
    logic              r_write;
    logic              r_ramsel;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_m0_ack;
    logic              r_m1_ack;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

`ifdef TINY_ARB_LOCK_EN
    logic r_lock_valid;
    logic r_lock_id;

    // A held lock hides the other requester while the owner keeps requesting.
    always_comb begin
        w_req0 = m0_req && !(r_lock_valid && r_lock_id && m1_req);
        w_req1 = m1_req && !(r_lock_valid && !r_lock_id && m0_req);
    end

    // Capture the grantee's lock at grant; release once the owner stops asking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_valid <= 1'b0;
            r_lock_id    <= 1'b0;
        end else if (w_start) begin
            r_lock_valid <= w_gnt_id ? m1_lock : m0_lock;
            r_lock_id    <= w_gnt_id;
        end else if (r_state == StIdle && r_lock_valid) begin
            if (r_lock_id ? !m1_req : !m0_req) begin
                r_lock_valid <= 1'b0;
            end
        end
    end
`else
    // Without locking the round-robin pick sees the raw requests.
    always_comb begin
        w_req0 = m0_req;
        w_req1 = m1_req;
    end
`endif

    tiny_rr_pick u_rr_pick (
        .clk        (clk),
        .reset      (reset),
        .i_req0     (w_req0),
        .i_req1     (w_req1),
        .i_grant_en (r_state == StIdle),
        .o_valid    (w_gnt_valid),
        .o_id       (w_gnt_id)
    );

    // FSM state and phase counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; w_start marks a grant, w_done the DONE->IDLE edge.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_start      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_gnt_valid) begin
                    w_state_next = StAccess;
                    w_cnt_next   = '0;
                    w_start      = 1'b1;
                end
            end
            StAccess: begin
                if (r_cnt == ACCESS_LAST) begin
                    w_state_next = StDone;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StDone: begin
                if (r_cnt == DONE_LAST) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                    w_done       = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Latch the grantee and its command; held untouched through ACCESS and DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt_id <= 1'b0;
            r_write  <= 1'b0;
            r_ramsel <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_start) begin
            r_gnt_id <= w_gnt_id;
            r_write  <= w_gnt_id ? m1_write  : m0_write;
            r_ramsel <= w_gnt_id ? m1_ramsel : m0_ramsel;
            r_addr   <= w_gnt_id ? m1_addr   : m0_addr;
            r_wdata  <= w_gnt_id ? m1_wdata  : m0_wdata;
        end
    end

    // One-cycle ack to the grantee and read-data capture at completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            r_m0_ack <= w_done && !r_gnt_id;
            r_m1_ack <= w_done && r_gnt_id;
            if (w_done && !r_write) begin
                if (r_gnt_id) begin
                    r_m1_rdata <= rdata;
                end else begin
                    r_m0_rdata <= rdata;
                end
            end
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        read  = (r_state == StAccess) && !r_write;
        write = (r_state == StAccess) && r_write;
    end

    assign addr     = r_addr;
    assign wdata    = r_wdata;
    assign ramsel   = r_ramsel;
    assign m0_ack   = r_m0_ack;
    assign m1_ack   = r_m1_ack;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_tiny_bus_arbiter.sv
// Directed bench for tiny_bus_arbiter with a behavioural code/data RAM.
// Define TINY_ARB_LOCK_EN to also exercise the lock feature.
module tb_tiny_bus_arbiter;

    logic       clk;
    logic       reset;
    logic       m0_req, m0_write, m0_ramsel;
    logic [7:0] m0_addr, m0_wdata, m0_rdata;
    logic       m0_ack;
    logic       m1_req, m1_write, m1_ramsel;
    logic [7:0] m1_addr, m1_wdata, m1_rdata;
    logic       m1_ack;
`ifdef TINY_ARB_LOCK_EN
    logic       m0_lock, m1_lock;
`endif
    logic       read, write, ramsel;
    logic [7:0] addr, wdata, rdata;

    logic [7:0] code_mem [256];
    logic [7:0] data_mem [256];

    int n_tests;
    int n_fail;

    tiny_bus_arbiter #(
        .ADDR_W (8),
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_write  (m0_write),
        .m0_ramsel (m0_ramsel),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_write  (m1_write),
        .m1_ramsel (m1_ramsel),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
`ifdef TINY_ARB_LOCK_EN
        .m0_lock   (m0_lock),
        .m1_lock   (m1_lock),
`endif
        .read      (read),
        .write     (write),
        .addr      (addr),
        .wdata     (wdata),
        .ramsel    (ramsel),
        .rdata     (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAMs: ramsel=1 data, ramsel=0 code.
    always @(posedge clk) begin
        if (write) begin
            if (ramsel) data_mem[addr] <= wdata;
            else        code_mem[addr] <= wdata;
        end
        if (read) rdata <= ramsel ? data_mem[addr] : code_mem[addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        m0_req = 0; m0_write = 0; m0_ramsel = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_write = 0; m1_ramsel = 0; m1_addr = 0; m1_wdata = 0;
`ifdef TINY_ARB_LOCK_EN
        m0_lock = 0; m1_lock = 0;
`endif
    endtask

    task automatic do_reset();
        clear_reqs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    // Every cycle: strobes exclusive; cycle after a strobe keeps addr/ramsel.
    logic       prev_strobe;
    logic [7:0] prev_addr;
    logic       prev_ramsel;
    initial prev_strobe = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_strobe = 0;
        end else begin
            check_eq("rw_exclusive", 32'(read && write), 32'd0);
            if (prev_strobe) begin
                check_eq("done_addr_stable", 32'(addr), 32'(prev_addr));
                check_eq("done_ramsel_stable", 32'(ramsel), 32'(prev_ramsel));
                check_eq("done_no_strobe", 32'(read || write), 32'd0);
            end
            prev_strobe = read || write;
            prev_addr   = addr;
            prev_ramsel = ramsel;
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 256; i++) begin
            code_mem[i] = 8'h00;
            data_mem[i] = 8'h00;
        end
        data_mem[8'h10] = 8'hAA;
        rdata = 8'h00;
        do_reset();

        // Reset state.
        check_eq("rst_read", 32'(read), 32'd0);
        check_eq("rst_write", 32'(write), 32'd0);
        check_eq("rst_addr", 32'(addr), 32'd0);
        check_eq("rst_wdata", 32'(wdata), 32'd0);
        check_eq("rst_ramsel", 32'(ramsel), 32'd0);
        check_eq("rst_m0_ack", 32'(m0_ack), 32'd0);
        check_eq("rst_m1_ack", 32'(m1_ack), 32'd0);
        check_eq("rst_m0_rdata", 32'(m0_rdata), 32'd0);
        check_eq("rst_m1_rdata", 32'(m1_rdata), 32'd0);

        // m0 reads data RAM 0x10 (0xAA).
        m0_req = 1; m0_write = 0; m0_ramsel = 1; m0_addr = 8'h10;
        check_eq("rd_T_read", 32'(read), 32'd0);
        step();
        check_eq("rd_T1_read", 32'(read), 32'd1);
        check_eq("rd_T1_write", 32'(write), 32'd0);
        check_eq("rd_T1_addr", 32'(addr), 32'h10);
        check_eq("rd_T1_ramsel", 32'(ramsel), 32'd1);
        step();
        check_eq("rd_T2_read", 32'(read), 32'd0);
        check_eq("rd_T2_ack", 32'(m0_ack), 32'd0);
        step();
        check_eq("rd_T3_ack", 32'(m0_ack), 32'd1);
        check_eq("rd_T3_rdata", 32'(m0_rdata), 32'hAA);
        check_eq("rd_T3_m1_ack", 32'(m1_ack), 32'd0);
        m0_req = 0;
        step();
        check_eq("rd_T4_ack", 32'(m0_ack), 32'd0);
        check_eq("rd_T4_read", 32'(read), 32'd0);

        // m1 writes code RAM 0x05 = 0x3C.
        m1_req = 1; m1_write = 1; m1_ramsel = 0; m1_addr = 8'h05; m1_wdata = 8'h3C;
        step();
        check_eq("wr_T1_write", 32'(write), 32'd1);
        check_eq("wr_T1_read", 32'(read), 32'd0);
        check_eq("wr_T1_wdata", 32'(wdata), 32'h3C);
        step();
        check_eq("wr_T2_write", 32'(write), 32'd0);
        step();
        check_eq("wr_T3_m1_ack", 32'(m1_ack), 32'd1);
        check_eq("wr_T3_m0_ack", 32'(m0_ack), 32'd0);
        check_eq("wr_code_mem", 32'(code_mem[8'h05]), 32'h3C);
        check_eq("wr_m1_rdata_hold", 32'(m1_rdata), 32'd0);
        check_eq("wr_m0_rdata_hold", 32'(m0_rdata), 32'hAA);
        m1_req = 0;
        step();

        // Both request continuously: m0, m1, m0, m1 with acks every 3 cycles.
        do_reset();
        m0_req = 1; m0_write = 0; m0_ramsel = 1; m0_addr = 8'h10;
        m1_req = 1; m1_write = 0; m1_ramsel = 0; m1_addr = 8'h05;
        for (int k = 1; k <= 12; k++) begin
            step();
            check_eq($sformatf("rr_m0_ack_%0d", k), 32'(m0_ack), 32'((k % 6) == 3));
            check_eq($sformatf("rr_m1_ack_%0d", k), 32'(m1_ack), 32'((k % 6) == 0));
            check_eq($sformatf("rr_read_%0d", k), 32'(read), 32'((k % 3) == 1));
            if (k == 3) check_eq("rr_m0_rdata", 32'(m0_rdata), 32'hAA);
            if (k == 6) check_eq("rr_m1_rdata", 32'(m1_rdata), 32'h3C);
        end
        clear_reqs();
        step();

        // Reset in the middle of a write ACCESS aborts it.
        do_reset();
        m0_req = 1; m0_write = 1; m0_ramsel = 1; m0_addr = 8'h20; m0_wdata = 8'h55;
        step();
        check_eq("abort_pre_write", 32'(write), 32'd1);
        #2;
        reset = 1;
        #1;
        check_eq("abort_write", 32'(write), 32'd0);
        check_eq("abort_read", 32'(read), 32'd0);
        check_eq("abort_addr", 32'(addr), 32'd0);
        reset = 0;
        m0_req = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq($sformatf("abort_no_ack_%0d", k), 32'(m0_ack), 32'd0);
            check_eq($sformatf("abort_idle_%0d", k), 32'(read || write), 32'd0);
        end
        check_eq("abort_mem", 32'(data_mem[8'h20]), 32'd0);
        check_eq("abort_m0_rdata", 32'(m0_rdata), 32'd0);
        m1_req = 1; m1_write = 0; m1_ramsel = 0; m1_addr = 8'h05;
        step();
        check_eq("post_abort_read", 32'(read), 32'd1);
        step();
        step();
        check_eq("post_abort_ack", 32'(m1_ack), 32'd1);
        check_eq("post_abort_rdata", 32'(m1_rdata), 32'h3C);
        m1_req = 0;
        step();
        check_eq("post_abort_ack_end", 32'(m1_ack), 32'd0);

`ifdef TINY_ARB_LOCK_EN
        // m1 locks for three accesses while m0 waits.
        do_reset();
        m1_req = 1; m1_lock = 1; m1_write = 0; m1_ramsel = 0; m1_addr = 8'h05;
        step();
        m0_req = 1; m0_write = 0; m0_ramsel = 1; m0_addr = 8'h10;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) step();
            check_eq($sformatf("lock_m1_ack_%0d", k), 32'(m1_ack), 32'(k == 3 || k == 6 || k == 9));
            check_eq($sformatf("lock_m0_ack_%0d", k), 32'(m0_ack), 32'(k == 12));
            if (k == 9) begin
                m1_req  = 0;
                m1_lock = 0;
            end
        end
        clear_reqs();
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
